xadc_drp_responder: RTL and testbench



---
 rtl/xadc_drp_responder_if.sv | 12 +
 rtl/xadc_drp_responder.sv | 212 +++++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_responder_if.sv
// axis_io: minimal AXI-Stream bundle (tdata/tvalid/tready) used for the
// responder's sample sinks.
interface axis_io #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport Sink   (input tdata, input tvalid, output tready);
   modport Source (output tdata, output tvalid, input tready);
endinterface

// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: DRP slave standing in for the XADC primitive; results come
// from two AXIS sinks, committed on periodic EOS. Optional macro XADC_DRP_RESPONDER_ERR_EN adds drp_err.
module xadc_drp_responder #(
   parameter int unsigned READ_LATENCY = 4,
   parameter int unsigned EOS_PERIOD   = 256,
   parameter logic [6:0]  VOLTAGE_ADDR = 7'h13,
   parameter logic [6:0]  CURRENT_ADDR = 7'h1B,
   parameter logic [6:0]  SCRATCH_ADDR = 7'h40
) (
   input  logic        xadc_dclk,
   input  logic        xadc_reset,
   input  logic [6:0]  xadc_daddr,
   input  logic        xadc_den,
   input  logic        xadc_dwe,
   input  logic [15:0] xadc_di,
   output logic [15:0] xadc_do,
   output logic        xadc_drdy,
   output logic        xadc_eos,
   output logic        xadc_busy,
`ifdef XADC_DRP_RESPONDER_ERR_EN
   output logic        drp_err,
`endif
   axis_io.Sink        voltage_sample,
   axis_io.Sink        current_sample
);

   localparam int unsigned      CNT_W    = (EOS_PERIOD > 1) ? $clog2(EOS_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EOS_PERIOD - 1);
   localparam logic [3:0]       LAT_LOAD = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESPOND
   } state_e;

   typedef struct packed {
      logic [15:0] stage;
      logic        full;
      logic [15:0] result;
   } chan_t;

   state_e             state_q, state_d;
   logic [3:0]         lat_q, lat_d;
   logic [6:0]         addr_q, addr_d;
   logic               we_q, we_d;
   logic [15:0]        wdata_q, wdata_d;
   logic [15:0]        do_q, do_d;
   logic               drdy_q, drdy_d;
   logic               busy_q, busy_d;
   logic               eos_q, eos_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        scratch_q, scratch_d;
   chan_t [1:0]        chan_q, chan_d;

   logic               fire;
   logic [6:0]         fire_addr;
   logic               fire_we;
   logic [15:0]        fire_di;
   logic [15:0]        rd_data;
   logic [1:0]         in_valid;
   logic [1:0]         in_ready;
   logic [1:0][15:0]   in_data;

   // Channel 0 is voltage, channel 1 is current.
   assign in_valid = {current_sample.tvalid, voltage_sample.tvalid};
   assign in_data  = {current_sample.tdata,  voltage_sample.tdata};
   assign in_ready = ~{chan_q[1].full, chan_q[0].full} & {2{~xadc_reset}};

   assign voltage_sample.tready = in_ready[0];
   assign current_sample.tready = in_ready[1];

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      lat_d     = lat_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      scratch_d = scratch_q;
      fire      = 1'b0;
      fire_addr = addr_q;
      fire_we   = we_q;
      fire_di   = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (xadc_den) begin
               addr_d  = xadc_daddr;
               we_d    = xadc_dwe;
               wdata_d = xadc_di;
               lat_d   = LAT_LOAD;
               if (READ_LATENCY == 1) begin
                  state_d   = ST_RESPOND;
                  fire      = 1'b1;
                  fire_addr = xadc_daddr;
                  fire_we   = xadc_dwe;
                  fire_di   = xadc_di;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) begin
               state_d = ST_RESPOND;
               fire    = 1'b1;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Results are read from the current (pre-commit) register contents.
      rd_data = 16'h0000;
      if (fire_addr == VOLTAGE_ADDR) begin
         rd_data = chan_q[0].result;
      end else if (fire_addr == CURRENT_ADDR) begin
         rd_data = chan_q[1].result;
      end else if (fire_addr == SCRATCH_ADDR) begin
         rd_data = scratch_q;
      end

      drdy_d = fire;
      do_d   = (fire && !fire_we) ? rd_data : 16'h0000;
      busy_d = (state_d != ST_IDLE);
      if (fire && fire_we && (fire_addr == SCRATCH_ADDR)) begin
         scratch_d = fire_di;
      end

      eos_d = (cnt_q == CNT_LAST);
      cnt_d = eos_d ? '0 : cnt_q + CNT_W'(1);

      for (int i = 0; i < 2; i++) begin
         chan_d[i] = chan_q[i];
         if (eos_d && chan_q[i].full) begin
            chan_d[i].result = chan_q[i].stage;
            chan_d[i].full   = 1'b0;
         end
         if (in_valid[i] && in_ready[i]) begin
            chan_d[i].stage = in_data[i];
            chan_d[i].full  = 1'b1;
         end
      end
   end

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         // NOTE: request latches are reset too, so a transaction aborted by reset
         // leaves no stale address or data behind.
         state_q   <= ST_IDLE;
         lat_q     <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         do_q      <= '0;
         drdy_q    <= 1'b0;
         busy_q    <= 1'b0;
         eos_q     <= 1'b0;
         cnt_q     <= '0;
         scratch_q <= '0;
         chan_q    <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless
         // of statement order.
         state_q   <= state_d;
         lat_q     <= lat_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         do_q      <= do_d;
         drdy_q    <= drdy_d;
         busy_q    <= busy_d;
         eos_q     <= eos_d;
         cnt_q     <= cnt_d;
         scratch_q <= scratch_d;
         chan_q    <= chan_d;
      end
   end

   assign xadc_do   = do_q;
   assign xadc_drdy = drdy_q;
   assign xadc_eos  = eos_q;
   assign xadc_busy = busy_q;

`ifdef XADC_DRP_RESPONDER_ERR_EN
   logic err_q, err_d;
   logic den_ignored;
   logic ro_write;

   assign den_ignored = xadc_den && (state_q != ST_IDLE);
   assign ro_write    = fire && fire_we &&
                        ((fire_addr == VOLTAGE_ADDR) || (fire_addr == CURRENT_ADDR));

   always_comb begin
      err_d = err_q | den_ignored | ro_write;
   end

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign drp_err = err_q;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: directed plan checks plus randomized traffic, compared every
// cycle against an event-level model (edge count since reset, pending-request deadline).
module tb_xadc_drp_responder;

   localparam int         RL  = 4;
   localparam int         EP  = 256;
   localparam logic [6:0] A_V = 7'h13;
   localparam logic [6:0] A_C = 7'h1B;
   localparam logic [6:0] A_S = 7'h40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  daddr = '0;
   logic        den = 1'b0;
   logic        dwe = 1'b0;
   logic [15:0] di = '0;
   logic [15:0] dout;
   logic        drdy, eos, busy;
`ifdef XADC_DRP_RESPONDER_ERR_EN
   logic        drp_err;
`endif

   axis_io v_if();
   axis_io c_if();

   always #5 clk = ~clk;

   xadc_drp_responder dut (
      .xadc_dclk      (clk),
      .xadc_reset     (rst),
      .xadc_daddr     (daddr),
      .xadc_den       (den),
      .xadc_dwe       (dwe),
      .xadc_di        (di),
      .xadc_do        (dout),
      .xadc_drdy      (drdy),
      .xadc_eos       (eos),
      .xadc_busy      (busy),
`ifdef XADC_DRP_RESPONDER_ERR_EN
      .drp_err        (drp_err),
`endif
      .voltage_sample (v_if),
      .current_sample (c_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired, got none, expected event at %0t", name, $time);
   endtask

   // Behavioural model: time is the number of edges since reset; a request is
   // answered at edge (accept + RL - 1) and blocks new requests one edge longer.
   bit          m_valid = 0;
   int          k, due;
   bit          pend, busy_before, accept;
   logic [6:0]  p_addr;
   logic        p_we;
   logic [15:0] p_di;
   logic [15:0] v_stage, v_res, c_stage, c_res, scratch;
   bit          v_full, c_full, v_hs, c_hs;
   logic [15:0] e_do;
   bit          e_drdy, e_eos, e_busy, e_err;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; k = 0; due = 0; pend = 0;
         v_stage = 0; v_res = 0; v_full = 0;
         c_stage = 0; c_res = 0; c_full = 0;
         scratch = 0;
         e_do = 0; e_drdy = 0; e_eos = 0; e_busy = 0; e_err = 0;
      end else begin
         k++;
         e_eos = (k % EP) == 0;
         busy_before = pend;
         accept = den && !busy_before;
         if (den && busy_before) e_err = 1;
         if (pend && k == due + 1) pend = 0;
         if (accept) begin
            pend = 1; due = k + RL - 1;
            p_addr = daddr; p_we = dwe; p_di = di;
         end
         e_drdy = 0;
         e_do = 0;
         v_hs = v_if.tvalid && !v_full;
         c_hs = c_if.tvalid && !c_full;
         if (pend && k == due) begin
            e_drdy = 1;
            if (!p_we) begin
               if (p_addr == A_V) e_do = v_res;
               else if (p_addr == A_C) e_do = c_res;
               else if (p_addr == A_S) e_do = scratch;
            end else if (p_addr == A_S) begin
               scratch = p_di;
            end else if (p_addr == A_V || p_addr == A_C) begin
               e_err = 1;
            end
         end
         if (e_eos && v_full) begin v_res = v_stage; v_full = 0; end
         if (e_eos && c_full) begin c_res = c_stage; c_full = 0; end
         if (v_hs) begin v_stage = v_if.tdata; v_full = 1; end
         if (c_hs) begin c_stage = c_if.tdata; c_full = 1; end
         e_busy = pend;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("drdy", drdy, e_drdy);
         check("do", dout, e_do);
         check("eos", eos, e_eos);
         check("busy", busy, e_busy);
         check("v_tready", v_if.tready, !rst && !v_full);
         check("c_tready", c_if.tready, !rst && !c_full);
`ifdef XADC_DRP_RESPONDER_ERR_EN
         check("drp_err", drp_err, e_err);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at posedge+1 of the cycle following the eos cycle.
   task automatic wait_eos();
      bit found = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (eos) begin found = 1; break; end
      end
      if (!found) fail("eos_timeout");
      tick();
   endtask

   task automatic drp_op(input logic we, input logic [6:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat, output logic eos_at);
      bit got = 0;
      rd = 0; lat = 0; eos_at = 0;
      den = 1; dwe = we; daddr = a; di = d;
      tick();
      den = 0; dwe = 0; di = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (drdy) begin got = 1; lat = i; rd = dout; eos_at = eos; break; end
      end
      if (!got) fail("drdy_timeout");
      tick();
      check("drdy_one_cycle", drdy, 1'b0);
   endtask

   task automatic push(input bit ch, input logic [15:0] d);
      bit hs = 0;
      if (ch) begin c_if.tvalid = 1; c_if.tdata = d; end
      else    begin v_if.tvalid = 1; v_if.tdata = d; end
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         hs = ch ? c_if.tready : v_if.tready;
         tick();
         if (hs) break;
      end
      if (ch) c_if.tvalid = 0; else v_if.tvalid = 0;
      if (!hs) fail("push_timeout");
   endtask

   logic [15:0] rd;
   int          lat, cnt, first;
   logic        ev;
   bit          vr, cr;

   initial begin
      v_if.tvalid = 0; v_if.tdata = 0;
      c_if.tvalid = 0; c_if.tdata = 0;

      // Reset, then free-running EOS with no stimulus.
      repeat (3) tick();
      check("tready_in_reset", {v_if.tready, c_if.tready}, 2'b00);
      rst = 0;
      first = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 0) check("tready_after_reset", {v_if.tready, c_if.tready}, 2'b11);
         if (eos) begin first = i; break; end
      end
      check("first_eos_cycle", first, 256);
      first = -1;
      for (int i = 1; i < 300; i++) begin
         @(negedge clk);
         if (eos) begin first = i; break; end
      end
      check("eos_period", first, 256);
      tick();

      // Push both channels, commit at EOS, read back.
      push(0, 16'hABC0);
      push(1, 16'h1230);
      wait_eos();
      drp_op(0, A_V, 0, rd, lat, ev);
      check("rd_voltage", rd, 16'hABC0);
      check("rd_latency", lat, 4);
      drp_op(0, A_C, 0, rd, lat, ev);
      check("rd_current", rd, 16'h1230);

      // Second push stalls until EOS.
      push(0, 16'h1111);
      v_if.tvalid = 1; v_if.tdata = 16'h2222;
      @(negedge clk);
      check("stall_tready", v_if.tready, 1'b0);
      tick();
      push(0, 16'h2222);
      drp_op(0, A_V, 0, rd, lat, ev);
      check("rd_first_push", rd, 16'h1111);
      wait_eos();
      drp_op(0, A_V, 0, rd, lat, ev);
      check("rd_second_push", rd, 16'h2222);

      // Scratch write/read; write to a result address is ignored.
      drp_op(1, A_S, 16'h5A5A, rd, lat, ev);
      check("wr_do_zero", rd, 16'h0000);
      check("wr_latency", lat, 4);
      drp_op(0, A_S, 0, rd, lat, ev);
      check("rd_scratch", rd, 16'h5A5A);
      drp_op(1, A_V, 16'hFFFF, rd, lat, ev);
      drp_op(0, A_V, 0, rd, lat, ev);
      check("rd_voltage_unwritten", rd, 16'h2222);
      drp_op(0, 7'h05, 0, rd, lat, ev);
      check("rd_unmapped", rd, 16'h0000);

      // drdy coincides with an EOS commit: old value, then new value.
      wait_eos();
      v_if.tvalid = 1; v_if.tdata = 16'h3333;
      tick();
      v_if.tvalid = 0;
      repeat (250) @(posedge clk);
      #1;
      drp_op(0, A_V, 0, rd, lat, ev);
      check("eos_coincide", ev, 1'b1);
      check("rd_precommit", rd, 16'h2222);
      drp_op(0, A_V, 0, rd, lat, ev);
      check("rd_postcommit", rd, 16'h3333);

      // den during WAIT is ignored.
      den = 1; dwe = 0; daddr = A_S;
      tick();
      den = 0;
      tick();
      den = 1; daddr = A_V;
      tick();
      den = 0;
      cnt = 0; rd = 0;
      repeat (12) begin
         @(negedge clk);
         if (drdy) begin cnt++; rd = dout; end
      end
      check("single_drdy", cnt, 1);
      check("ignored_den_data", rd, 16'h5A5A);
`ifdef XADC_DRP_RESPONDER_ERR_EN
      check("drp_err_set", drp_err, 1'b1);
`endif
      tick();

      // Reset mid-WAIT aborts the request.
      den = 1; dwe = 0; daddr = A_S;
      tick();
      den = 0;
      tick();
      rst = 1;
      tick();
      tick();
      rst = 0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (drdy) cnt++;
      end
      check("no_drdy_after_reset", cnt, 0);
      tick();
      drp_op(0, A_S, 0, rd, lat, ev);
      check("scratch_reset", rd, 16'h0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         vr = v_if.tready;
         cr = c_if.tready;
         tick();
         if (!v_if.tvalid || vr) begin
            v_if.tvalid = ($urandom_range(0, 3) == 0);
            v_if.tdata  = 16'($urandom);
         end
         if (!c_if.tvalid || cr) begin
            c_if.tvalid = ($urandom_range(0, 3) == 0);
            c_if.tdata  = 16'($urandom);
         end
         den = ($urandom_range(0, 4) == 0);
         dwe = 1'($urandom_range(0, 1));
         di  = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       daddr = A_V;
            1:       daddr = A_C;
            2:       daddr = A_S;
            default: daddr = 7'($urandom);
         endcase
         rst = ($urandom_range(0, 1499) == 0);
      end
      den = 0; rst = 0;
      v_if.tvalid = 0; c_if.tvalid = 0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
